// File: rtl/iob_gpio_in_filter.sv
// iob_gpio_in_filter: per-bit pad input conditioning for iob_gpio.
// Each bit goes through a synchroniser and then a programmable-stability
// debouncer. The debounced level feeds edge detection, which drives a sticky,
// maskable interrupt-pending vector.
module iob_gpio_in_filter #(
  parameter int GPIO_W      = 32,
  parameter int DEB_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic [DEB_W-1:0]  cfg_deb_limit,
  input  logic [GPIO_W-1:0] pad_in,
  output logic [GPIO_W-1:0] gpio_clean,
  output logic [GPIO_W-1:0] rise_pulse,
  output logic [GPIO_W-1:0] fall_pulse,
  input  logic [GPIO_W-1:0] rise_en,
  input  logic [GPIO_W-1:0] fall_en,
  input  logic [GPIO_W-1:0] irq_clr,
  output logic [GPIO_W-1:0] irq_pending,
  output logic              irq
);

  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

  // sync_reg[0] samples the pads; the last stage is the synchronised level.
  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_reg;
  logic [GPIO_W-1:0]                  sync_lvl;
  logic [GPIO_W-1:0]                  clean_q_reg;
  logic [GPIO_W-1:0]                  pending_reg;
  logic [GPIO_W-1:0]                  pending_next;

  // Plain flop chain with no logic between stages, so metastability can settle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], pad_in};
    end
  end

  assign sync_lvl = sync_reg[SYNC_STAGES-1];

  // Each bit has its own debouncer. Bits share no state with each other.
  generate
    for (genvar gi = 0; gi < GPIO_W; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_reg;
      logic [DEB_W-1:0] cnt_next;
      logic             clean_reg;
      logic             clean_next;
      logic             at_limit;

      // A limit of 0 accepts on the first differing cycle, just like a limit of 1.
      // The >= compare lets a lowered limit take effect at once, even mid-count.
      assign at_limit = (cfg_deb_limit == '0) ||
                        (cnt_reg >= (cfg_deb_limit - DEB_ONE));

      // Counter: clear on agreement, accept the new level at the limit, else count.
      // The counter stops below the limit, so it cannot wrap.
      always_comb begin
        cnt_next   = cnt_reg;
        clean_next = clean_reg;
        if (sync_lvl[gi] == clean_reg) begin
          cnt_next = '0;
        end else if (at_limit) begin
          clean_next = sync_lvl[gi];
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + DEB_ONE;
        end
      end

      // Debounce state register.
      always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
          cnt_reg   <= '0;
          clean_reg <= 1'b0;
        end else begin
          cnt_reg   <= cnt_next;
          clean_reg <= clean_next;
        end
      end

      assign gpio_clean[gi] = clean_reg;
    end
  endgenerate

  // Debounced level delayed by one cycle, used for edge detection.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      clean_q_reg <= '0;
    end else begin
      clean_q_reg <= gpio_clean;
    end
  end

  assign rise_pulse = gpio_clean & ~clean_q_reg;
  assign fall_pulse = ~gpio_clean & clean_q_reg;

  // A new enabled edge wins over a clear in the same cycle.
  // Clearing an enable does not drop a flag that is already pending.
  always_comb begin
    pending_next = (pending_reg & ~irq_clr)
                 | (rise_pulse & rise_en)
                 | (fall_pulse & fall_en);
  end

  // Sticky pending flags.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pending_reg <= '0;
    end else begin
      pending_reg <= pending_next;
    end
  end

  assign irq_pending = pending_reg;
  assign irq         = |pending_reg;

endmodule

// File: tb/tb_iob_gpio_in_filter.sv
// Bench for iob_gpio_in_filter. A table of per-cycle vectors is applied.
// Expected outputs are pushed to a scoreboard when a vector is driven, then
// popped and compared after the edge. Hand-written sequences follow for
// reset while a bit is counting and for a limit change while a bit is counting.
module tb_iob_gpio_in_filter;

  localparam int GPIO_W = 32;
  localparam int DEB_W  = 16;

  logic              clk = 1'b0;
  logic              arst_n = 1'b0;
  logic [DEB_W-1:0]  cfg_deb_limit = '0;
  logic [GPIO_W-1:0] pad_in = '0;
  logic [GPIO_W-1:0] gpio_clean;
  logic [GPIO_W-1:0] rise_pulse;
  logic [GPIO_W-1:0] fall_pulse;
  logic [GPIO_W-1:0] rise_en = '0;
  logic [GPIO_W-1:0] fall_en = '0;
  logic [GPIO_W-1:0] irq_clr = '0;
  logic [GPIO_W-1:0] irq_pending;
  logic              irq;

  iob_gpio_in_filter #(.GPIO_W(GPIO_W), .DEB_W(DEB_W), .SYNC_STAGES(2)) dut (
    .clk           (clk),
    .arst_n        (arst_n),
    .cfg_deb_limit (cfg_deb_limit),
    .pad_in        (pad_in),
    .gpio_clean    (gpio_clean),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse),
    .rise_en       (rise_en),
    .fall_en       (fall_en),
    .irq_clr       (irq_clr),
    .irq_pending   (irq_pending),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit                rst;    // pulse reset (and check it) before this vector
    logic [DEB_W-1:0]  limit;
    logic [GPIO_W-1:0] pad;
    logic [GPIO_W-1:0] ren;
    logic [GPIO_W-1:0] fen;
    logic [GPIO_W-1:0] clr;
    logic [GPIO_W-1:0] e_clean;
    logic [GPIO_W-1:0] e_rise;
    logic [GPIO_W-1:0] e_fall;
    logic [GPIO_W-1:0] e_pend;
    string             tag;
  } vec_t;

  typedef struct {
    logic [GPIO_W-1:0] clean;
    logic [GPIO_W-1:0] rise;
    logic [GPIO_W-1:0] fall;
    logic [GPIO_W-1:0] pend;
    logic              irq;
    string             tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_applied = 0;
  int   n_miscompares = 0;

  function automatic void add(input bit rst, input int limit, input logic [31:0] pad,
                              input logic [31:0] ren, input logic [31:0] fen,
                              input logic [31:0] clr, input logic [31:0] ec,
                              input logic [31:0] er, input logic [31:0] ef,
                              input logic [31:0] ep, input string tag);
    vec_t v;
    v.rst = rst; v.limit = DEB_W'(limit); v.pad = pad; v.ren = ren; v.fen = fen;
    v.clr = clr; v.e_clean = ec; v.e_rise = er; v.e_fall = ef; v.e_pend = ep;
    v.tag = tag;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("chk %s: %h ok", name, act);
    end
  endtask

  // Asserts reset between clock edges and checks that every output clears at once.
  task automatic do_reset();
    @(negedge clk);
    pad_in = '0; rise_en = '0; fall_en = '0; irq_clr = '0;
    #2 arst_n = 1'b0;
    #1;
    chk("reset_outputs", gpio_clean | rise_pulse | fall_pulse | irq_pending | {31'd0, irq}, 32'd0);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // s1: limit 0, bit 0, fall enabled: clean and rise at cycle 3, pending after fall.
    add(1, 0, 32'h1, 0, 32'h1, 0, 0,     0,     0, 0, "s1");
    add(0, 0, 32'h1, 0, 32'h1, 0, 0,     0,     0, 0, "s1");
    add(0, 0, 32'h1, 0, 32'h1, 0, 32'h1, 32'h1, 0, 0, "s1_rise");
    add(0, 0, 32'h1, 0, 32'h1, 0, 32'h1, 0,     0, 0, "s1");
    add(0, 0, 32'h0, 0, 32'h1, 0, 32'h1, 0,     0, 0, "s1");
    add(0, 0, 32'h0, 0, 32'h1, 0, 32'h1, 0,     0, 0, "s1");
    add(0, 0, 32'h0, 0, 32'h1, 0, 0,     0, 32'h1, 0, "s1_fall");
    add(0, 0, 32'h0, 0, 32'h1, 0, 0,     0,     0, 32'h1, "s1_pend");
    add(0, 0, 32'h0, 0, 32'h1, 0, 0,     0,     0, 32'h1, "s1_pend");
    // s1b: limit 1 gives the same timing as limit 0.
    add(1, 1, 32'h2, 0, 0, 0, 0,     0,     0, 0, "s1b");
    add(0, 1, 32'h2, 0, 0, 0, 0,     0,     0, 0, "s1b");
    add(0, 1, 32'h2, 0, 0, 0, 32'h2, 32'h2, 0, 0, "s1b_rise");
    add(0, 1, 32'h2, 0, 0, 0, 32'h2, 0,     0, 0, "s1b");
    // s2: limit 4, bit 3. A 3-cycle glitch is rejected; a steady level lands at cycle 6.
    for (int i = 0; i < 3; i++) add(i == 0, 4, 32'h8, 0, 0, 0, 0, 0, 0, 0, "s2_glitch");
    for (int i = 0; i < 5; i++) add(0, 4, 32'h0, 0, 0, 0, 0, 0, 0, 0, "s2_glitch");
    for (int i = 0; i < 5; i++) add(0, 4, 32'h8, 0, 0, 0, 0, 0, 0, 0, "s2_count");
    add(0, 4, 32'h8, 0, 0, 0, 32'h8, 32'h8, 0, 0, "s2_rise");
    for (int i = 0; i < 4; i++) add(0, 4, 32'h8, 0, 0, 0, 32'h8, 0, 0, 0, "s2_hold");
    // s3: bit 5, rise enabled only. Disabling the enable keeps pending; clear drops it.
    add(1, 0, 32'h20, 32'h20, 0, 0, 0,      0,      0,      0,      "s3");
    add(0, 0, 32'h20, 32'h20, 0, 0, 0,      0,      0,      0,      "s3");
    add(0, 0, 32'h20, 32'h20, 0, 0, 32'h20, 32'h20, 0,      0,      "s3_rise");
    add(0, 0, 32'h20, 32'h20, 0, 0, 32'h20, 0,      0,      32'h20, "s3_pend");
    add(0, 0, 32'h00, 0,      0, 0, 32'h20, 0,      0,      32'h20, "s3_hold");
    add(0, 0, 32'h00, 0,      0, 0, 32'h20, 0,      0,      32'h20, "s3_hold");
    add(0, 0, 32'h00, 0,      0, 0, 0,      0,      32'h20, 32'h20, "s3_fall");
    add(0, 0, 32'h00, 0,      0, 0, 0,      0,      0,      32'h20, "s3_nofallset");
    add(0, 0, 32'h00, 0,      0, 32'h20, 0, 0,      0,      0,      "s3_clr");
    add(0, 0, 32'h00, 0,      0, 0, 0,      0,      0,      0,      "s3_clr");
    // s4: bit 7, a clear in the same cycle as the rise pulse loses to the set.
    add(1, 0, 32'h80, 32'h80, 0, 0,      0,      0,      0, 0,      "s4");
    add(0, 0, 32'h80, 32'h80, 0, 0,      0,      0,      0, 0,      "s4");
    add(0, 0, 32'h80, 32'h80, 0, 0,      32'h80, 32'h80, 0, 0,      "s4_rise");
    add(0, 0, 32'h80, 32'h80, 0, 32'h80, 32'h80, 0,      0, 32'h80, "s4_setwins");
    add(0, 0, 32'h80, 32'h80, 0, 0,      32'h80, 0,      0, 32'h80, "s4_hold");
    add(0, 0, 32'h80, 32'h80, 0, 32'h80, 32'h80, 0,      0, 0,      "s4_clr");
    add(0, 0, 32'h80, 32'h80, 0, 0,      32'h80, 0,      0, 0,      "s4_clr");

    arst_n = 1'b0;
    #12;

    foreach (vecs[k]) begin
      exp_t e;
      exp_t got;
      if (vecs[k].rst) do_reset();
      @(negedge clk);
      cfg_deb_limit = vecs[k].limit;
      pad_in  = vecs[k].pad;
      rise_en = vecs[k].ren;
      fall_en = vecs[k].fen;
      irq_clr = vecs[k].clr;
      e.clean = vecs[k].e_clean; e.rise = vecs[k].e_rise; e.fall = vecs[k].e_fall;
      e.pend  = vecs[k].e_pend;  e.irq  = |vecs[k].e_pend; e.tag = vecs[k].tag;
      sb.push_back(e);
      step();
      got = sb.pop_front();
      n_applied++;
      if (gpio_clean !== got.clean || rise_pulse !== got.rise || fall_pulse !== got.fall ||
          irq_pending !== got.pend || irq !== got.irq) begin
        n_miscompares++;
        $display("FAIL vec %0d %s: got clean=%h rise=%h fall=%h pend=%h irq=%b, expected clean=%h rise=%h fall=%h pend=%h irq=%b",
                 k, got.tag, gpio_clean, rise_pulse, fall_pulse, irq_pending, irq,
                 got.clean, got.rise, got.fall, got.pend, got.irq);
      end else begin
        $display("vec %0d %s: clean=%h rise=%h fall=%h pend=%h irq=%b", k, got.tag,
                 gpio_clean, rise_pulse, fall_pulse, irq_pending, irq);
      end
    end

    // s5: reset while bit 2 is mid-count. Outputs clear at once, then a full 100 cycles restart.
    do_reset();
    cfg_deb_limit = '0; pad_in = 32'h1; rise_en = 32'h1;
    repeat (5) step();
    chk("s5_pre_clean", gpio_clean, 32'h1);
    chk("s5_pre_pend", irq_pending, 32'h1);
    cfg_deb_limit = 16'd100; pad_in = 32'h5; rise_en = '0;
    repeat (52) step();                       // bit 2 count reaches 50
    chk("s5_mid_clean", gpio_clean, 32'h1);
    #2 arst_n = 1'b0;
    #1;
    chk("s5_async_clean", gpio_clean, 32'h0);
    chk("s5_async_pend", irq_pending | {31'd0, irq}, 32'h0);
    @(negedge clk);
    arst_n = 1'b1;
    repeat (101) step();
    chk("s5_post_101_clean", gpio_clean, 32'h0);
    step();
    chk("s5_post_102_clean", gpio_clean, 32'h5);
    chk("s5_post_102_rise", rise_pulse, 32'h5);

    // s6: limit lowered from 100 to 2 while bit 9 is at count 50. The level lands on the next edge.
    do_reset();
    cfg_deb_limit = 16'd100; pad_in = 32'h200;
    repeat (52) step();
    chk("s6_before", gpio_clean, 32'h0);
    cfg_deb_limit = 16'd2;
    step();
    chk("s6_after_clean", gpio_clean, 32'h200);
    chk("s6_after_rise", rise_pulse, 32'h200);

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
